console_uart_rx: RTL and testbench
==================================

Name: console_uart_rx

Overview:
- Serial-to-console bridge for the input side of the console interface.
- Receives 8N1 UART frames on the RX pin.
- Buffers the received bytes in a small FIFO.
- Presents each byte to the processor wrapper on CONSOLE_IN, using the four-phase CONSOLE_IN_valid/CONSOLE_IN_ack handshake the wrapper already implements.
- Sits between the board UART pin and the wrapper's CONSOLE_IN, CONSOLE_IN_valid and CONSOLE_IN_ack ports.

Parameters:
- CLK_FREQ_HZ, 100000000, frequency of CLK in Hz.
- BAUD_RATE, 115200, serial bit rate. DIV = CLK_FREQ_HZ/BAUD_RATE (integer division), must be >= 4.
- FIFO_DEPTH, 4, number of byte entries in the receive FIFO. Must be a power of two and >= 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- RX  in  1  asynchronous UART serial input; idles high.
- CONSOLE_IN  out  8  byte presented to the wrapper.
- CONSOLE_IN_valid  out  1  CONSOLE_IN holds an unconsumed byte.
- CONSOLE_IN_ack  in  1  wrapper acknowledge, four-phase.
- RX_frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- RX_overrun  out  1  one-cycle pulse: good byte arrived with FIFO full, byte discarded.

Behaviour:
- Reset values: CONSOLE_IN=8'h00, CONSOLE_IN_valid=0, RX_frame_err=0, RX_overrun=0; FIFO empty; both FSMs idle; synchroniser flops = 1.
- RX passes through a 2-flop synchroniser. All references below use the synchronised value rxs.
- Receive FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: when rxs==0, load baud counter with DIV/2-1 and go to R_START.
  - R_START: when counter reaches 0, sample rxs. If 1 (glitch), return to R_IDLE with no pulse. If 0, reload counter with DIV-1, set bit index to 0, go to R_DATA.
  - R_DATA: on each counter expiry, shift rxs into the shift register LSB first and reload DIV-1. After bit 7, go to R_STOP.
  - R_STOP: on counter expiry, sample rxs.
    - If 1 and FIFO not full: push the byte.
    - If 1 and FIFO full: pulse RX_overrun, drop the byte.
    - If 0: pulse RX_frame_err, drop the byte.
    - In all cases return to R_IDLE. From R_IDLE, a new frame is accepted only on the next cycle where rxs==0.
- Sampling point: the middle of each bit, ±1 cycle.
- FIFO: read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full and empty are decided by the pointer MSB comparison. A push and a pop in the same cycle on a full FIFO is legal; the push succeeds and no overrun is flagged.
- Handshake FSM states: H_IDLE, H_VALID, H_ACKED.
  - H_IDLE: if the FIFO is not empty and CONSOLE_IN_ack==0, pop the FIFO head into CONSOLE_IN, set valid=1, go to H_VALID. Latency: byte pushed at edge N gives valid=1 at edge N+2 at the earliest.
  - H_VALID: hold CONSOLE_IN and valid stable. When ack==1, go to H_ACKED; valid stays 1.
  - H_ACKED: when ack==0, set valid=0 and go to H_IDLE.
  - Valid therefore falls only after ack has risen and then fallen.
  - Valid stays low for at least one cycle between consecutive bytes.
  - CONSOLE_IN retains the last byte while valid=0.
- ack asserted while in H_IDLE is ignored until it deasserts; no pop occurs.
- RESET asserted mid-frame or mid-handshake: all state, the FIFO and the outputs return to reset values immediately. A partial frame is lost. After release, the first falling edge of rxs starts a new frame.
- Error pulses are exactly one cycle wide and never assert together.

Decomposition:
- Package console_pkg holds:
  - state enumerations for the receive and handshake FSMs;
  - the function computing DIV from CLK_FREQ_HZ and BAUD_RATE;
  - byte width constant 8.
- Sub-module console_rx_fifo (synchronous FIFO with push, pop, full, empty, parameterised by depth) is instantiated once.

Test Plan:
All scenarios use CLK_FREQ_HZ=16, BAUD_RATE=1, so DIV=16.
- Single byte: send frame 8'h41 with ack low; bench raises ack 5 cycles after valid, drops it 3 cycles later. Required: CONSOLE_IN=8'h41 while valid; valid falls the cycle after ack falls; no error pulses.
- Back-to-back: send 8'h50, 8'h41, 8'h0D with the bench never acking until all three frames are in. Required: bytes delivered in order 50, 41, 0D; valid low ≥1 cycle between them.
- Overrun: send 5 frames with no ack. Required: first 4 bytes delivered in order after acking; RX_overrun pulses exactly once, at the 5th stop bit.
- Framing error: send 8'hA5 with stop bit 0. Required: RX_frame_err one-cycle pulse; valid never rises; the following good frame 8'h3C delivers normally.
- Glitch and reset: a 4-cycle low pulse on RX gives no byte and no error. Assert RESET=0 during bit 3 of a frame. Required: outputs return to reset values, FIFO empty; the next full frame 8'h7E is received correctly.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and constants for the console UART receive bridge.
// Holds the FSM state encodings and the baud divisor helper.
package console_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    H_IDLE,
    H_VALID,
    H_ACKED
  } hs_state_t;

  // Clock cycles per serial bit; callers keep the result >= 4.
  function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// Synchronous byte FIFO between the UART receiver and the console handshake.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module console_rx_fifo
  import console_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (rd_en) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/console_uart_rx.sv
// 8N1 UART receiver feeding the processor wrapper's CONSOLE_IN port through a
// small FIFO and a four-phase valid/ack handshake.
module console_uart_rx
  import console_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX,
  output logic [BYTE_W-1:0] CONSOLE_IN,
  output logic              CONSOLE_IN_valid,
  input  logic              CONSOLE_IN_ack,
  output logic              RX_frame_err,
  output logic              RX_overrun
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIV / 2 - 1);

  // Handshake contract: CONSOLE_IN_valid rises with a new byte on CONSOLE_IN and
  // both stay stable until CONSOLE_IN_ack has risen and then fallen; valid then
  // drops for at least one cycle. ack seen while idle blocks the next pop.

  logic rx_meta;
  logic rxs;

  rx_state_t         rx_state, rx_state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [BYTE_W-1:0] shreg, shreg_n;
  logic              push;
  logic              frame_err_n;
  logic              overrun_n;

  hs_state_t         hs_state, hs_state_n;
  logic [BYTE_W-1:0] data_n;
  logic              pop;
  logic              head_ready;

  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_state     <= R_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      RX_frame_err <= 1'b0;
      RX_overrun   <= 1'b0;
    end else begin
      rx_state     <= rx_state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      RX_frame_err <= frame_err_n;
      RX_overrun   <= overrun_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    push        = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (!rxs) begin
          cnt_n      = HALF_BIT;
          rx_state_n = R_START;
        end
      end
      R_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            rx_state_n = R_IDLE;
          end else begin
            cnt_n      = FULL_BIT;
            bit_idx_n  = '0;
            rx_state_n = R_DATA;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (cnt == '0) begin
          shreg_n = {rxs, shreg[BYTE_W-1:1]};
          cnt_n   = FULL_BIT;
          if (bit_idx == 3'd7) begin
            rx_state_n = R_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      R_STOP: begin
        if (cnt == '0) begin
          rx_state_n = R_IDLE;
          if (!rxs) begin
            frame_err_n = 1'b1;
          end else if (!fifo_full || pop) begin
            push = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  console_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head must be seen non-empty for a whole cycle before it is popped, so a
  // byte written at edge N is presented no earlier than edge N+2.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_ready <= 1'b0;
    end else begin
      head_ready <= !fifo_empty;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hs_state   <= H_IDLE;
      CONSOLE_IN <= '0;
    end else begin
      hs_state   <= hs_state_n;
      CONSOLE_IN <= data_n;
    end
  end

  always_comb begin
    hs_state_n = hs_state;
    data_n     = CONSOLE_IN;
    pop        = 1'b0;
    case (hs_state)
      H_IDLE: begin
        if (head_ready && !fifo_empty && !CONSOLE_IN_ack) begin
          pop        = 1'b1;
          data_n     = fifo_head;
          hs_state_n = H_VALID;
        end
      end
      H_VALID: begin
        if (CONSOLE_IN_ack) begin
          hs_state_n = H_ACKED;
        end
      end
      H_ACKED: begin
        if (!CONSOLE_IN_ack) begin
          hs_state_n = H_IDLE;
        end
      end
      default: hs_state_n = H_IDLE;
    endcase
  end

  assign CONSOLE_IN_valid = (hs_state != H_IDLE);

endmodule

// File: tb/tb_console_uart_rx.sv
// Directed bench for console_uart_rx at 16 clocks per bit: single byte,
// back-to-back, overrun, framing error, glitch and mid-frame reset.
module tb_console_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] console_in;
  logic       console_in_valid;
  logic       console_in_ack;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int fe_rise = 0, fe_hi = 0, ov_rise = 0, ov_hi = 0, both_hi = 0, valid_rise = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, valid_prev = 1'b0;

  console_uart_rx #(
    .CLK_FREQ_HZ (16),
    .BAUD_RATE   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK              (clk),
    .RESET            (reset),
    .RX               (rx),
    .CONSOLE_IN       (console_in),
    .CONSOLE_IN_valid (console_in_valid),
    .CONSOLE_IN_ack   (console_in_ack),
    .RX_frame_err     (rx_frame_err),
    .RX_overrun       (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Pulse monitor: counts high cycles and rising edges of the status outputs.
  always @(negedge clk) begin
    if (rx_frame_err) fe_hi++;
    if (rx_frame_err && !fe_prev) fe_rise++;
    if (rx_overrun) ov_hi++;
    if (rx_overrun && !ov_prev) ov_rise++;
    if (rx_frame_err && rx_overrun) both_hi++;
    if (console_in_valid && !valid_prev) valid_rise++;
    fe_prev    = rx_frame_err;
    ov_prev    = rx_overrun;
    valid_prev = console_in_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!console_in_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_up"}, 32'(console_in_valid), 32'd1);
  endtask

  // Full four-phase exchange: ack 5 cycles after valid, released 3 cycles later.
  task automatic ack_byte(input logic [7:0] exp, input string tag);
    wait_valid(tag);
    check({tag, "_data"}, 32'(console_in), 32'(exp));
    repeat (5) @(negedge clk);
    check({tag, "_data_hold"}, 32'(console_in), 32'(exp));
    console_in_ack = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_valid_acked"}, 32'(console_in_valid), 32'd1);
    console_in_ack = 1'b0;
    @(negedge clk);
    check({tag, "_valid_fall"}, 32'(console_in_valid), 32'd0);
    check({tag, "_data_retain"}, 32'(console_in), 32'(exp));
  endtask

  initial begin
    int fe0, ov0, vr0;
    reset          = 1'b0;
    rx             = 1'b1;
    console_in_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(console_in), 32'h00);
    check("rst_valid", 32'(console_in_valid), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte
    send_frame(8'h41, 1'b1);
    ack_byte(8'h41, "single");
    check("single_no_fe", 32'(fe_rise), 32'd0);
    check("single_no_ov", 32'(ov_rise), 32'd0);

    // Back-to-back, acked only after all three are in
    send_frame(8'h50, 1'b1);
    send_frame(8'h41, 1'b1);
    send_frame(8'h0D, 1'b1);
    ack_byte(8'h50, "b2b0");
    ack_byte(8'h41, "b2b1");
    ack_byte(8'h0D, "b2b2");

    // Overrun: ack held high keeps the head in the FIFO, so four entries fill it
    console_in_ack = 1'b1;
    ov0 = ov_rise;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    check("ovr_none_at_4", 32'(ov_rise - ov0), 32'd0);
    send_frame(8'h05, 1'b1);
    check("ovr_once_at_5", 32'(ov_rise - ov0), 32'd1);
    check("ovr_ack_idle_blocks", 32'(console_in_valid), 32'd0);
    console_in_ack = 1'b0;
    @(negedge clk);
    ack_byte(8'h01, "ovr0");
    ack_byte(8'h02, "ovr1");
    ack_byte(8'h03, "ovr2");
    ack_byte(8'h04, "ovr3");
    repeat (20) @(negedge clk);
    check("ovr_fifo_drained", 32'(console_in_valid), 32'd0);

    // Framing error, then a good frame
    fe0 = fe_rise;
    vr0 = valid_rise;
    send_frame(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_pulse", 32'(fe_rise - fe0), 32'd1);
    check("ferr_no_valid", 32'(valid_rise - vr0), 32'd0);
    send_frame(8'h3C, 1'b1);
    ack_byte(8'h3C, "ferr_next");

    // Glitch: 4-cycle low pulse
    vr0 = valid_rise;
    fe0 = fe_rise;
    ov0 = ov_rise;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", 32'(valid_rise - vr0), 32'd0);
    check("glitch_no_fe", 32'(fe_rise - fe0), 32'd0);
    check("glitch_no_ov", 32'(ov_rise - ov0), 32'd0);

    // Reset during bit 3 with one byte presented and one queued
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("pre_rst_valid", 32'(console_in_valid), 32'd1);
    check("pre_rst_data", 32'(console_in), 32'h11);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_data", 32'(console_in), 32'h00);
    check("midrst_valid", 32'(console_in_valid), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("postrst_fifo_empty", 32'(console_in_valid), 32'd0);
    send_frame(8'h7E, 1'b1);
    ack_byte(8'h7E, "postrst");

    check("total_fe_rises", 32'(fe_rise), 32'd1);
    check("total_fe_width", 32'(fe_hi), 32'd1);
    check("total_ov_rises", 32'(ov_rise), 32'd1);
    check("total_ov_width", 32'(ov_hi), 32'd1);
    check("errs_exclusive", 32'(both_hi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
